// File: rtl/xor_arb_pkg.sv
// Shared definitions for the round-robin XOR-sharing arbiter: FSM encodings
// and default sizing.
package xor_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } arb_state_e;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_W     = 1;
   localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/xor_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit strictly after
// 'last', wrapping around NREQ.
module rr_pick
   import xor_arb_pkg::*;
#(
   parameter  int NREQ = DEF_NREQ,
   localparam int ID_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] last,
   output logic [NREQ-1:0] gnt_onehot,
   output logic [ID_W-1:0] gnt_idx,
   output logic            any
);

   logic            w_found;
   logic [ID_W-1:0] w_cand;

   assign any = |req;

   // Scan forward from last+1; the last slot visited is 'last' itself
   always_comb begin
      gnt_onehot = {NREQ{1'b0}};
      gnt_idx    = {ID_W{1'b0}};
      w_found    = 1'b0;
      w_cand     = {ID_W{1'b0}};
      for (int k = 1; k <= NREQ; k++) begin
         w_cand = ID_W'((int'(last) + k) % NREQ);
         if (!w_found && req[w_cand]) begin
            w_found             = 1'b1;
            gnt_onehot[w_cand]  = 1'b1;
            gnt_idx             = w_cand;
         end else begin
            w_found = w_found;
         end
      end
   end

endmodule

// File: rtl/xor_share_arbiter.sv
// Time-shares one external two-input XOR unit among NREQ requesters with a
// round-robin grant and a three-cycle IDLE -> ISSUE -> RESP sequence.
module xor_share_arbiter
   import xor_arb_pkg::*;
#(
   parameter  int NREQ  = DEF_NREQ,
   parameter  int W     = DEF_W,
   parameter  int CNT_W = DEF_CNT_W,
   localparam int ID_W  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_in1,
   input  logic [NREQ*W-1:0] req_in2,
   output logic [W-1:0]      xor_in1,
   output logic [W-1:0]      xor_in2,
   input  logic [W-1:0]      xor_out,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [W-1:0]      rsp_data,
   output logic [ID_W-1:0]   grant_id,
   output logic              busy,
   output logic [CNT_W-1:0]  op_count
);

   arb_state_e        r_state;
   arb_state_e        w_next;
   logic [W-1:0]      r_xor_in1, r_xor_in2, r_rsp_data;
   logic [NREQ-1:0]   r_rsp_valid;
   logic [ID_W-1:0]   r_grant_id;
   logic [CNT_W-1:0]  r_op_count;
   logic [NREQ-1:0]   w_gnt_onehot, w_id_onehot;
   logic [ID_W-1:0]   w_gnt_idx;
   logic              w_any;
   logic [W-1:0]      w_sel1, w_sel2;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req        (req_valid),
      .last       (r_grant_id),
      .gnt_onehot (w_gnt_onehot),
      .gnt_idx    (w_gnt_idx),
      .any        (w_any)
   );

   // Operand mux for the winning requester and one-hot of the held grant
   always_comb begin
      w_sel1      = {W{1'b0}};
      w_sel2      = {W{1'b0}};
      w_id_onehot = {NREQ{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt_onehot[i]) begin
            w_sel1 = req_in1[i*W +: W];
            w_sel2 = req_in2[i*W +: W];
         end else begin
            w_sel1 = w_sel1;
            w_sel2 = w_sel2;
         end
         w_id_onehot[i] = (ID_W'(i) == r_grant_id);
      end
   end

   // Next-state and ready: acceptance happens only in IDLE
   always_comb begin
      w_next    = ST_IDLE;
      req_ready = {NREQ{1'b0}};
      case (r_state)
         ST_IDLE: begin
            req_ready = w_gnt_onehot;
            if (w_any) begin
               w_next = ST_ISSUE;
            end else begin
               w_next = ST_IDLE;
            end
         end
         ST_ISSUE: w_next = ST_RESP;
         ST_RESP:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Datapath registers: capture operands, sample the XOR result, count completions
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_xor_in1   <= {W{1'b0}};
         r_xor_in2   <= {W{1'b0}};
         r_rsp_valid <= {NREQ{1'b0}};
         r_rsp_data  <= {W{1'b0}};
         r_grant_id  <= ID_W'(NREQ - 1);
         r_op_count  <= {CNT_W{1'b0}};
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_xor_in1  <= w_sel1;
                  r_xor_in2  <= w_sel2;
                  r_grant_id <= w_gnt_idx;
               end
            end
            ST_ISSUE: begin
               r_rsp_data  <= xor_out;
               r_rsp_valid <= w_id_onehot;
            end
            ST_RESP: begin
               r_rsp_valid <= {NREQ{1'b0}};
               r_op_count  <= r_op_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            default: begin
               r_rsp_valid <= {NREQ{1'b0}};
            end
         endcase
      end
   end

   assign xor_in1   = r_xor_in1;
   assign xor_in2   = r_xor_in2;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign grant_id  = r_grant_id;
   assign op_count  = r_op_count;
   assign busy      = (r_state == ST_ISSUE) || (r_state == ST_RESP);

endmodule
